// File: rtl/reg_file_scoreboard_if.sv
// ---------------------------------------------------------------------------
// reg_file_scoreboard_if
//
// Purpose: bundles the read, immediate-write, reservation and writeback
// signals of the register file scoreboard into one interface. The issue and
// execute logic of the core uses the master side. The register file uses the
// slave side. Clock and reset are plain module ports and are not part of it.
//
// Signals (from the register file's point of view):
//   rdAddr        in   READ_PORTS*AW     read addresses, port i at [i*AW +: AW]
//   rdData        out  READ_PORTS*WIDTH  forwarded read data
//   rdBusy        out  READ_PORTS        addressed register still reserved
//   wrEnable      in   1                 immediate (ALU) write strobe
//   wrAddr        in   AW                immediate write address
//   wrData        in   WIDTH             immediate write data
//   reserveValid  in   1                 reservation request
//   reserveAddr   in   AW                register to reserve
//   reserveReady  out  1                 reservation can be accepted
//   wbValid       in   1                 writeback of a reserved register
//   wbAddr        in   AW                writeback address
//   wbData        in   WIDTH             writeback data
//   pendingCount  out  CW                number of busy registers
//   hazardError   out  1                 sticky protocol-violation flag
//   errorClear    in   1                 clears hazardError
// ---------------------------------------------------------------------------
interface reg_file_scoreboard_if #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 8,
    parameter int READ_PORTS  = 2,
    parameter int MAX_PENDING = 4
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(MAX_PENDING + 1);

    logic [READ_PORTS*AW-1:0]    rdAddr;
    logic [READ_PORTS*WIDTH-1:0] rdData;
    logic [READ_PORTS-1:0]       rdBusy;
    logic                        wrEnable;
    logic [AW-1:0]               wrAddr;
    logic [WIDTH-1:0]            wrData;
    logic                        reserveValid;
    logic [AW-1:0]               reserveAddr;
    logic                        reserveReady;
    logic                        wbValid;
    logic [AW-1:0]               wbAddr;
    logic [WIDTH-1:0]            wbData;
    logic [CW-1:0]               pendingCount;
    logic                        hazardError;
    logic                        errorClear;

    // Core side: issues reads, writes, reservations and writebacks.
    modport master (
        output rdAddr, wrEnable, wrAddr, wrData,
        output reserveValid, reserveAddr,
        output wbValid, wbAddr, wbData, errorClear,
        input  rdData, rdBusy, reserveReady, pendingCount, hazardError
    );

    // Register file side.
    modport slave (
        input  rdAddr, wrEnable, wrAddr, wrData,
        input  reserveValid, reserveAddr,
        input  wbValid, wbAddr, wbData, errorClear,
        output rdData, rdBusy, reserveReady, pendingCount, hazardError
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_file_scoreboard
//
// Purpose: parametrised register file with a per-register busy scoreboard.
// Single-cycle ALU results write immediately through the wr* port.
// Multi-cycle operations first reserve a destination register, which marks
// it busy. They later retire it through the wb* port, which stores the data
// and clears busy. Reads are combinational. They forward same-cycle legal
// writes and writebacks. rdBusy tells the issue logic to stall on a register
// that is still pending. Writes to a busy register, writebacks to a register
// that is not busy, and any access beyond DEPTH set a sticky hazardError.
//
// Ports:
//   clock     in   rising-edge clock
//   isResetN  in   asynchronous active-low reset; clears data, busy, count
//                  and the error flag
//   bus       slave modport of reg_file_scoreboard_if (see that file)
//
// Parameters:
//   WIDTH, DEPTH, READ_PORTS, MAX_PENDING  as in the interface
//   ZERO_REG  when 1, register 0 reads as 0 and ignores writes/reservations
// ---------------------------------------------------------------------------
module reg_file_scoreboard #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 8,
    parameter int READ_PORTS  = 2,
    parameter int MAX_PENDING = 4,
    parameter bit ZERO_REG    = 1'b1
) (
    input logic                  clock,
    input logic                  isResetN,
    reg_file_scoreboard_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(MAX_PENDING + 1);

    logic [WIDTH-1:0] registers [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [CW-1:0]    pending_count;
    logic             hazard_error;

    // An address is out of range only when DEPTH is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] addr);
        return 32'(addr) < DEPTH;
    endfunction

    function automatic logic is_zero(input logic [AW-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    // Out-of-range addresses are never busy. The guard keeps the index legal.
    function automatic logic busy_at(input logic [AW-1:0] addr);
        return in_range(addr) ? busy[addr] : 1'b0;
    endfunction

    // ------------------------------------------------------------------
    // Legality of this cycle's requests
    // ------------------------------------------------------------------
    logic wr_legal, wr_error;
    logic wb_legal, wb_error;
    logic reserve_ready, reserve_fire;

    // A write to the zero register is dropped silently. A write to a busy
    // or nonexistent register is a hazard.
    assign wr_legal = bus.wrEnable && in_range(bus.wrAddr) &&
                      !is_zero(bus.wrAddr) && !busy_at(bus.wrAddr);
    assign wr_error = bus.wrEnable &&
                      (!in_range(bus.wrAddr) || busy_at(bus.wrAddr));

    // The zero register is never busy, so a writeback to it is a hazard as well.
    assign wb_legal = bus.wbValid && busy_at(bus.wbAddr);
    assign wb_error = bus.wbValid && !wb_legal;

    // A reservation is refused if it collides with a same-cycle immediate
    // write. Without this, the write would land in a register that has just
    // become pending.
    assign reserve_ready = in_range(bus.reserveAddr) &&
                           !busy_at(bus.reserveAddr) &&
                           (pending_count < CW'(MAX_PENDING)) &&
                           !is_zero(bus.reserveAddr) &&
                           !(bus.wrEnable && (bus.wrAddr == bus.reserveAddr));
    assign reserve_fire  = bus.reserveValid && reserve_ready;

    // ------------------------------------------------------------------
    // Read ports with forwarding: zero/out-of-range, then writeback, then
    // immediate write, then stored state.
    // ------------------------------------------------------------------
    logic [AW-1:0]               rd_addr [READ_PORTS];
    logic [READ_PORTS*WIDTH-1:0] rd_data;
    logic [READ_PORTS-1:0]       rd_busy;

    // NOTE: every output of this block is given a default before the loop.
    // A path that left one unassigned would infer a latch.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < READ_PORTS; i++) begin
            rd_addr[i] = bus.rdAddr[i*AW +: AW];
            if (is_zero(rd_addr[i]) || !in_range(rd_addr[i])) begin
                rd_data[i*WIDTH +: WIDTH] = '0;
            end else if (wb_legal && (bus.wbAddr == rd_addr[i])) begin
                rd_data[i*WIDTH +: WIDTH] = bus.wbData;
            end else if (wr_legal && (bus.wrAddr == rd_addr[i])) begin
                rd_data[i*WIDTH +: WIDTH] = bus.wrData;
            end else begin
                rd_data[i*WIDTH +: WIDTH] = registers[rd_addr[i]];
            end
            // A register that retires this cycle no longer needs a stall.
            rd_busy[i] = busy_at(rd_addr[i]) &&
                         !(wb_legal && (bus.wbAddr == rd_addr[i]));
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // NOTE: the register array is reset along with the scoreboard. After a
    // reset every register must read 0, not leftover contents.
    always_ff @(posedge clock or negedge isResetN) begin
        if (!isResetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                registers[i] <= '0;
            end
            busy          <= '0;
            pending_count <= '0;
            hazard_error  <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments, so every
            // decision in this block sees the values from before the edge.
            // wr_legal and wb_legal are mutually exclusive on one address.
            // One needs the target idle and the other needs it busy.
            if (wr_legal) registers[bus.wrAddr] <= bus.wrData;
            if (wb_legal) registers[bus.wbAddr] <= bus.wbData;

            if (reserve_fire) busy[bus.reserveAddr] <= 1'b1;
            if (wb_legal)     busy[bus.wbAddr]      <= 1'b0;

            // A reserve and a retire in the same cycle leave the count as is.
            case ({reserve_fire, wb_legal})
                2'b10:   pending_count <= pending_count + CW'(1);
                2'b01:   pending_count <= pending_count - CW'(1);
                default: pending_count <= pending_count;
            endcase

            // A new violation takes priority over a same-cycle clear.
            if (wr_error || wb_error) begin
                hazard_error <= 1'b1;
            end else if (bus.errorClear) begin
                hazard_error <= 1'b0;
            end
        end
    end

    assign bus.rdData       = rd_data;
    assign bus.rdBusy       = rd_busy;
    assign bus.reserveReady = reserve_ready;
    assign bus.pendingCount = pending_count;
    assign bus.hazardError  = hazard_error;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_file_scoreboard
//
// Self-checking bench for reg_file_scoreboard with default parameters
// (8 x 8 bits, 2 read ports, 4 outstanding reservations, zero register).
// Expected values are queued when a stimulus is applied. They are popped in
// order when the matching DUT output is sampled.
// ---------------------------------------------------------------------------
module tb_reg_file_scoreboard;
    localparam int WIDTH       = 8;
    localparam int DEPTH       = 8;
    localparam int READ_PORTS  = 2;
    localparam int MAX_PENDING = 4;
    localparam int AW          = 3;

    logic clock = 1'b0;
    logic isResetN;

    always #5 clock = ~clock;

    reg_file_scoreboard_if #(
        .WIDTH(WIDTH), .DEPTH(DEPTH),
        .READ_PORTS(READ_PORTS), .MAX_PENDING(MAX_PENDING)
    ) bus ();

    reg_file_scoreboard #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .READ_PORTS(READ_PORTS),
        .MAX_PENDING(MAX_PENDING), .ZERO_REG(1'b1)
    ) dut (
        .clock    (clock),
        .isResetN (isResetN),
        .bus      (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expect_t;

    expect_t sb_q[$];
    int      tests_run    = 0;
    int      tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] value);
        expect_t e;
        e.tag   = tag;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] actual);
        expect_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, actual, e.value);
        end
    endtask

    task automatic idle();
        bus.rdAddr       = '0;
        bus.wrEnable     = 1'b0;
        bus.wrAddr       = '0;
        bus.wrData       = '0;
        bus.reserveValid = 1'b0;
        bus.reserveAddr  = '0;
        bus.wbValid      = 1'b0;
        bus.wbAddr       = '0;
        bus.wbData       = '0;
        bus.errorClear   = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge and outputs are
    // sampled 2 units later, well away from the next edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_rd(input int port, input logic [AW-1:0] addr);
        bus.rdAddr[port*AW +: AW] = addr;
    endtask

    function automatic logic [WIDTH-1:0] rd_data(input int port);
        return bus.rdData[port*WIDTH +: WIDTH];
    endfunction

    initial begin
        idle();
        isResetN = 1'b0;
        #12;

        // Reset state.
        set_rd(0, 3'd3);
        bus.reserveAddr = 3'd1;
        expect_out("reset_pending", 0);
        expect_out("reset_hazard", 0);
        expect_out("reset_rd0", 0);
        expect_out("reset_ready_addr1", 1);
        expect_out("reset_busy", 0);
        #1;
        observe(bus.pendingCount);
        observe(bus.hazardError);
        observe(rd_data(0));
        observe(bus.reserveReady);
        observe(bus.rdBusy);
        isResetN = 1'b1;
        tick();

        // Immediate write with same-cycle forwarding on both ports.
        idle();
        bus.wrEnable = 1'b1; bus.wrAddr = 3'd3; bus.wrData = 8'h5A;
        set_rd(0, 3'd3); set_rd(1, 3'd3);
        expect_out("wr_fwd_port0", 8'h5A);
        expect_out("wr_fwd_port1", 8'h5A);
        settle();
        observe(rd_data(0));
        observe(rd_data(1));
        tick();
        idle();
        set_rd(0, 3'd3);
        expect_out("wr_state", 8'h5A);
        settle();
        observe(rd_data(0));

        // Zero register: writes ignored, reservations refused, no hazard.
        bus.wrEnable = 1'b1; bus.wrAddr = 3'd0; bus.wrData = 8'hFF;
        set_rd(0, 3'd0);
        expect_out("zero_fwd", 0);
        settle();
        observe(rd_data(0));
        tick();
        idle();
        set_rd(0, 3'd0);
        bus.reserveValid = 1'b1; bus.reserveAddr = 3'd0;
        expect_out("zero_state", 0);
        expect_out("zero_reserve_ready", 0);
        settle();
        observe(rd_data(0));
        observe(bus.reserveReady);
        tick();
        idle();
        expect_out("zero_hazard", 0);
        expect_out("zero_pending", 0);
        settle();
        observe(bus.hazardError);
        observe(bus.pendingCount);

        // Reserve 5, then an illegal immediate write to it.
        bus.reserveValid = 1'b1; bus.reserveAddr = 3'd5;
        expect_out("rsv5_ready", 1);
        settle();
        observe(bus.reserveReady);
        tick();
        idle();
        set_rd(1, 3'd5);
        expect_out("rsv5_busy", 1);
        expect_out("rsv5_pending", 1);
        settle();
        observe(bus.rdBusy[1]);
        observe(bus.pendingCount);
        bus.wrEnable = 1'b1; bus.wrAddr = 3'd5; bus.wrData = 8'h11;
        expect_out("illegal_wr_no_fwd", 0);
        settle();
        observe(rd_data(1));
        tick();
        idle();
        set_rd(1, 3'd5);
        expect_out("illegal_wr_hazard", 1);
        expect_out("illegal_wr_reg5", 0);
        expect_out("illegal_wr_still_busy", 1);
        settle();
        observe(bus.hazardError);
        observe(rd_data(1));
        observe(bus.rdBusy[1]);
        bus.errorClear = 1'b1;
        tick();
        idle();
        expect_out("error_clear", 0);
        settle();
        observe(bus.hazardError);

        // Retire 5 through the writeback port, with forwarding.
        bus.wbValid = 1'b1; bus.wbAddr = 3'd5; bus.wbData = 8'h55;
        set_rd(1, 3'd5);
        expect_out("wb5_fwd", 8'h55);
        expect_out("wb5_busy_masked", 0);
        settle();
        observe(rd_data(1));
        observe(bus.rdBusy[1]);
        tick();
        idle();
        set_rd(1, 3'd5);
        expect_out("wb5_pending", 0);
        expect_out("wb5_state", 8'h55);
        expect_out("wb5_hazard", 0);
        settle();
        observe(bus.pendingCount);
        observe(rd_data(1));
        observe(bus.hazardError);

        // Fill all reservation slots.
        for (int a = 1; a <= 4; a++) begin
            bus.reserveValid = 1'b1; bus.reserveAddr = 3'(a);
            expect_out($sformatf("fill_ready_%0d", a), 1);
            settle();
            observe(bus.reserveReady);
            tick();
            idle();
        end
        bus.reserveAddr = 3'd6;
        expect_out("full_pending", 4);
        expect_out("full_ready_addr6", 0);
        settle();
        observe(bus.pendingCount);
        observe(bus.reserveReady);

        // Writeback 2 and reserve 6 together: the reserve must wait a cycle.
        bus.wbValid = 1'b1; bus.wbAddr = 3'd2; bus.wbData = 8'h33;
        bus.reserveValid = 1'b1; bus.reserveAddr = 3'd6;
        set_rd(0, 3'd2); set_rd(1, 3'd6);
        expect_out("full_wb_ready", 0);
        expect_out("full_wb_fwd", 8'h33);
        expect_out("full_wb_busy", 2'b00);
        settle();
        observe(bus.reserveReady);
        observe(rd_data(0));
        observe(bus.rdBusy);
        tick();
        bus.wbValid = 1'b0;
        expect_out("retry_pending", 3);
        expect_out("retry_ready", 1);
        settle();
        observe(bus.pendingCount);
        observe(bus.reserveReady);
        tick();
        idle();
        set_rd(0, 3'd2); set_rd(1, 3'd6);
        expect_out("retry_done_pending", 4);
        expect_out("retry_reg2", 8'h33);
        expect_out("retry_busy", 2'b10);
        settle();
        observe(bus.pendingCount);
        observe(rd_data(0));
        observe(bus.rdBusy);

        // Writeback to idle register 7 while clearing: the violation wins.
        bus.wbValid = 1'b1; bus.wbAddr = 3'd7; bus.wbData = 8'h77;
        bus.errorClear = 1'b1;
        set_rd(0, 3'd7);
        expect_out("illegal_wb_no_fwd", 0);
        settle();
        observe(rd_data(0));
        tick();
        idle();
        set_rd(0, 3'd7);
        expect_out("illegal_wb_hazard", 1);
        expect_out("illegal_wb_reg7", 0);
        expect_out("illegal_wb_pending", 4);
        settle();
        observe(bus.hazardError);
        observe(rd_data(0));
        observe(bus.pendingCount);
        bus.errorClear = 1'b1;
        tick();
        idle();
        expect_out("illegal_wb_cleared", 0);
        settle();
        observe(bus.hazardError);

        // Retire 4, reserve it again, then reset in the middle of the cycle.
        bus.wbValid = 1'b1; bus.wbAddr = 3'd4; bus.wbData = 8'h44;
        tick();
        idle();
        bus.reserveValid = 1'b1; bus.reserveAddr = 3'd4;
        expect_out("rsv4_ready", 1);
        settle();
        observe(bus.reserveReady);
        tick();
        idle();
        set_rd(0, 3'd4);
        expect_out("rsv4_pending", 4);
        expect_out("rsv4_busy", 1);
        settle();
        observe(bus.pendingCount);
        observe(bus.rdBusy[0]);
        #2;
        isResetN = 1'b0;
        set_rd(1, 3'd2);
        expect_out("midreset_pending", 0);
        expect_out("midreset_busy", 0);
        expect_out("midreset_reg4", 0);
        expect_out("midreset_reg2", 0);
        expect_out("midreset_hazard", 0);
        #1;
        observe(bus.pendingCount);
        observe(bus.rdBusy);
        observe(rd_data(0));
        observe(rd_data(1));
        observe(bus.hazardError);
        #2;
        isResetN = 1'b1;
        tick();
        idle();
        bus.wbValid = 1'b1; bus.wbAddr = 3'd4; bus.wbData = 8'h99;
        set_rd(0, 3'd4);
        expect_out("stale_wb_no_fwd", 0);
        settle();
        observe(rd_data(0));
        tick();
        idle();
        set_rd(0, 3'd4);
        expect_out("stale_wb_hazard", 1);
        expect_out("stale_wb_pending", 0);
        expect_out("stale_wb_reg4", 0);
        settle();
        observe(bus.hazardError);
        observe(bus.pendingCount);
        observe(rd_data(0));

        // A reservation that collides with a same-cycle immediate write.
        bus.wrEnable = 1'b1; bus.wrAddr = 3'd7; bus.wrData = 8'h70;
        bus.reserveAddr = 3'd7;
        expect_out("wr_collide_ready", 0);
        settle();
        observe(bus.reserveReady);
        bus.reserveAddr = 3'd6;
        expect_out("wr_other_ready", 1);
        #1;
        observe(bus.reserveReady);
        tick();
        idle();

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/reg_file_scoreboard.md
# reg_file_scoreboard

Parametrised register file with write-through forwarding and a per-register busy scoreboard. It succeeds the fixed eight-by-eight register array inside the CPU core. Single-cycle ALU results write immediately. Multi-cycle operations reserve a destination register and later retire it through a separate writeback port. Pending registers are flagged to the issue logic so the core can stall instead of reading stale values.

## Interface
Parameters:
- WIDTH, 8, data width of each register.
- DEPTH, 8, number of registers; address width AW = clog2(DEPTH).
- READ_PORTS, 2, number of independent combinational read ports.
- MAX_PENDING, 4, maximum outstanding reservations; count width CW = clog2(MAX_PENDING+1).
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores all writes and reservations.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- isResetN  in  1  reset, asynchronous, active-low.
- rdAddr  in  READ_PORTS*AW  read addresses; port i at bits [i*AW +: AW].
- rdData  out  READ_PORTS*WIDTH  read data, forwarded.
- rdBusy  out  READ_PORTS  1 = addressed register has an unretired reservation.
- wrEnable  in  1  immediate (ALU) write strobe.
- wrAddr  in  AW  immediate write address.
- wrData  in  WIDTH  immediate write data.
- reserveValid  in  1  request to mark reserveAddr busy.
- reserveAddr  in  AW  register to reserve.
- reserveReady  out  1  reservation accepted this cycle when high with reserveValid.
- wbValid  in  1  writeback of a reserved register.
- wbAddr  in  AW  writeback address.
- wbData  in  WIDTH  writeback data.
- pendingCount  out  CW  number of busy registers.
- hazardError  out  1  sticky protocol-violation flag.
- errorClear  in  1  synchronous clear of hazardError.

## Operation
- State: registers[DEPTH], busy[DEPTH], pendingCount, hazardError.
- Read port i returns the first match in this order:
  - 0 if ZERO_REG and rdAddr==0.
  - wbData if a legal wbValid targets rdAddr.
  - wrData if a legal wrEnable targets rdAddr.
  - Otherwise registers[rdAddr].
- rdBusy[i] = busy[rdAddr] and not (legal wbValid to rdAddr this cycle).
- Legal immediate write: wrEnable, target not busy, not zero register. Its data is stored at the edge.
- Illegal immediate write: target busy. The data is dropped and hazardError is set. A write to register 0 is silently ignored and is not an error.
- reserveReady = !busy[reserveAddr] and pendingCount < MAX_PENDING and !(ZERO_REG and reserveAddr==0) and !(wrEnable and wrAddr==reserveAddr).
- Handshake: reserveValid and reserveReady sets busy[reserveAddr] and increments the count.
- Legal writeback: wbValid with busy[wbAddr] set. It stores wbData, clears busy, and decrements the count.
- Illegal writeback: target not busy. The data is dropped and hazardError is set.
- Simultaneous accepted reserve and legal writeback: the count is unchanged. The same address cannot occur, because busy blocks reserveReady.
- hazardError clears when errorClear is high. A new violation in the same cycle wins, so the flag stays 1.
- Addresses >= DEPTH when DEPTH is not a power of two: reads return 0, writes and writebacks are dropped with hazardError set, and reserveReady is low.

## Timing
- Reads are combinational, with zero-latency forwarding from both write ports.
- Writes, reservations and busy changes become visible in state after the next rising edge.
- reserveReady is combinational from registered state plus wrEnable/wrAddr. The requester may hold reserveValid until it sees reserveReady.
- Reset assertion asynchronously clears all registers, busy, pendingCount and hazardError to 0. reserveReady then follows its equation (1 for any nonzero valid address).
- Reset mid-operation discards all pending reservations. A later writeback to those registers is illegal and flags hazardError.

## Test plan
- Reset, then wrEnable addr 3 data 0x5A; in the same cycle read addr 3 -> rdData 0x5A (forwarded); the next cycle still 0x5A from state.
- Write 0xFF to register 0 -> reads 0; reserve addr 0 -> reserveReady 0; hazardError stays 0.
- Reserve addr 5 -> rdBusy 1, pendingCount 1; wrEnable addr 5 data 0x11 -> hazardError 1, register unchanged; errorClear -> 0.
- Reserve addrs 1,2,3,4 (MAX_PENDING 4) -> pendingCount 4, reserveReady 0 for addr 6. Writeback addr 2 data 0x33 with reserve addr 6 in the same cycle -> the reserve is refused. The next cycle the reserve is accepted, pendingCount stays 4, and reg2 reads 0x33.
- Writeback to non-busy addr 7 -> hazardError 1, register 7 unchanged, pendingCount unchanged.
- Reserve addr 4, assert isResetN low mid-cycle -> busy, pendingCount and registers 0 immediately. Writeback addr 4 after release -> hazardError 1.
